mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, SHALL set the maximum cycles spent waiting on one MFC edge (effective only with MEM_TIMEOUT_EN).
REQ-002 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset.
REQ-004 Port req  input  1  CPU access request; sampled only in IDLE.
REQ-005 Port wr  input  1  access type: 1 = write, 0 = read.
REQ-006 Port addr  input  16  access address.
REQ-007 Port wdata  input  16  write data.
REQ-008 Port rdata  output  16  last read data.
REQ-009 Port done  output  1  one-cycle completion pulse.
REQ-010 Port busy  output  1  high from request acceptance until done is high.
REQ-011 Port err  output  1  timeout flag, valid while done is high.
REQ-012 Port MAR_OUT  output  16  memory address.
REQ-013 Port MDR_OUT  output  16  write data to the memory datain.
REQ-014 Port RW  output  1  memory direction: 1 = read, 0 = write.
REQ-015 Port MEM_EN  output  1  memory strobe; the memory acts on its rising edge.
REQ-016 Port MEM_DATA  input  16  memory Dataout.
REQ-017 Port MFC  input  1  memory function complete; asynchronous to clk.

Function
REQ-018 MFC SHALL pass through a 2-flop synchronizer before use; the synchronized value is mfc_s.
REQ-019 FSM states SHALL be IDLE, SETUP, STROBE, RELEASE and DONE.
REQ-020 IDLE: on req=1, latch addr/wr/wdata into MAR_OUT/RW (RW = ~wr)/MDR_OUT, set busy=1 and go to SETUP; otherwise stay in IDLE.
REQ-021 SETUP: hold MEM_EN=0 for exactly one cycle so that address, RW and data are stable before the strobe; then go to STROBE.
REQ-022 STROBE: drive MEM_EN=1; on mfc_s=1, capture MEM_DATA into rdata (reads only) and go to RELEASE.
REQ-023 RELEASE: drive MEM_EN=0; on mfc_s=0, go to DONE.
REQ-024 DONE: done=1 for one cycle, busy cleared on the same edge that leaves DONE, then go to IDLE.
REQ-025 MAR_OUT, RW and MDR_OUT SHALL remain stable from SETUP through DONE.
REQ-026 Writes SHALL leave rdata unchanged.
REQ-027 req asserted while busy=1 SHALL be ignored; there is no queuing.
REQ-028 req held high during DONE SHALL start a new access only after returning to IDLE.
REQ-029 Minimum spacing SHALL be one IDLE cycle between consecutive accesses.
REQ-030 MFC already high on entry to STROBE (a stale acknowledge) SHALL be treated as a completion; the bench must not produce this case.
REQ-031 err SHALL be 0 on every done pulse when MEM_TIMEOUT_EN is not defined.

Reset
REQ-032 reset=0 SHALL force, asynchronously and in any state: IDLE, MEM_EN=0, RW=1, MAR_OUT=0, MDR_OUT=0, rdata=0, done=0, busy=0, err=0, synchronizer flops=0, timeout counter=0.
REQ-033 Reset during STROBE SHALL drop MEM_EN immediately; the aborted access SHALL NOT produce a done pulse.

Configuration
REQ-034 With MEM_TIMEOUT_EN defined:
- an 8-bit-or-wider counter SHALL clear on entry to STROBE and on entry to RELEASE, and increment each cycle in those states;
- on reaching TIMEOUT_CYCLES: MEM_EN=0, go to DONE with err=1, rdata unchanged.
REQ-035 Without MEM_TIMEOUT_EN: no counter is built, STROBE and RELEASE wait indefinitely, and err is tied to 0.

Verification
REQ-036 Read: req, wr=0, addr=0x0000 -> MAR_OUT=0x0000, RW=1, one MEM_EN pulse, done pulse, rdata=0xA03A, err=0.
REQ-037 Write then read: write 0x1234 to 0xFFFF -> RW=0 and MDR_OUT=0x1234 during MEM_EN; then read 0xFFFF -> rdata=0x1234; rdata unchanged after the write.
REQ-038 Back-to-back and ignored request: read 0x0007, then req pulsed while busy -> only one access occurs; next read of 0x0003 -> rdata=0x6002.
REQ-039 Reset mid-access: reset=0 two cycles into STROBE -> MEM_EN=0 and all outputs at reset values within the same cycle; no done pulse.
REQ-040 Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16): memory model never raises MFC -> done with err=1 at STROBE entry+16 cycles, rdata unchanged; without the macro, busy stays 1.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// CPU-side controller for an asynchronous MFC-handshake memory.
// Optional MEM_TIMEOUT_EN builds a bounded wait on each MFC edge.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic [15:0] MAR_OUT,
  output logic [15:0] MDR_OUT,
  output logic        RW,
  output logic        MEM_EN,
  input  logic [15:0] MEM_DATA,
  input  logic        MFC
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, RELEASE, DONE
  } state_t;

  state_t state_q, state_d;
  logic   mfc_q1, mfc_s;
  logic   tmo, tmo_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mfc_q1 <= 1'b0;
      mfc_s  <= 1'b0;
    end else begin
      mfc_q1 <= MFC;
      mfc_s  <= mfc_q1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    tmo_hit = 1'b0;
    unique case (state_q)
      IDLE:    if (req) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE: begin
        if (mfc_s) begin
          state_d = RELEASE;
        end else if (tmo) begin
          state_d = DONE;
          tmo_hit = 1'b1;
        end
      end
      RELEASE: begin
        if (!mfc_s) begin
          state_d = DONE;
        end else if (tmo) begin
          state_d = DONE;
          tmo_hit = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign MEM_EN = (state_q == STROBE);
  assign done   = (state_q == DONE);
  assign busy   = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MAR_OUT <= 16'h0000;
      MDR_OUT <= 16'h0000;
      RW      <= 1'b1;
      rdata   <= 16'h0000;
    end else begin
      if (state_q == IDLE && req) begin
        MAR_OUT <= addr;
        MDR_OUT <= wdata;
        RW      <= ~wr;
      end
      if (state_q == STROBE && mfc_s && RW)
        rdata <= MEM_DATA;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CW-1:0] cnt_q;
  logic          err_q;

  assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign err = err_q;

  // Restarts on every state change, so each MFC edge gets a full budget
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (state_q == STROBE || state_q == RELEASE) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      err_q <= 1'b0;
    else if (state_q == IDLE && req) err_q <= 1'b0;
    else if (tmo_hit)                err_q <= 1'b1;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  logic unused_tmo_hit;

  assign tmo            = 1'b0;
  assign err            = 1'b0;
  assign unused_tmo_hit = tmo_hit;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a reactive MFC memory model.
// Define MEM_TIMEOUT_EN to exercise the timeout path.
module tb_mem_access_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [15:0] wdata = 16'h0;
  logic [15:0] MEM_DATA = 16'h0;
  logic        MFC = 1'b0;
  logic [15:0] rdata, MAR_OUT, MDR_OUT;
  logic        done, busy, err, RW, MEM_EN;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  bit mute = 1'b0;
  bit ok;
  int e0, d0, n;

  logic        cap_rw;
  logic [15:0] cap_mar, cap_mdr;
  logic [15:0] mem [0:65535];

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .done     (done),
    .busy     (busy),
    .err      (err),
    .MAR_OUT  (MAR_OUT),
    .MDR_OUT  (MDR_OUT),
    .RW       (RW),
    .MEM_EN   (MEM_EN),
    .MEM_DATA (MEM_DATA),
    .MFC      (MFC)
  );

  always @(posedge MEM_EN) begin
    en_cnt++;
    cap_rw  = RW;
    cap_mar = MAR_OUT;
    cap_mdr = MDR_OUT;
  end

  always @(posedge MEM_EN) begin
    if (!mute) begin
      #3;
      if (!RW) mem[MAR_OUT] = MDR_OUT;
      MEM_DATA = mem[MAR_OUT];
      MFC = 1'b1;
    end
  end

  always @(negedge MEM_EN) begin
    #3;
    MFC = 1'b0;
  end

  always @(posedge clk) if (done) done_cnt++;

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(bit w, logic [15:0] a, logic [15:0] d);
    @(negedge clk);
    req = 1'b1;
    wr = w;
    addr = a;
    wdata = d;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_en(output bit got);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (MEM_EN) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    mem[16'h0000] = 16'hA03A;
    mem[16'h0003] = 16'h6002;
    mem[16'h0007] = 16'h0777;

    repeat (3) @(posedge clk);
    #1;
    chk1("rst_mem_en", MEM_EN, 1'b0);
    chk1("rst_rw", RW, 1'b1);
    chk16("rst_mar", MAR_OUT, 16'h0000);
    chk16("rst_mdr", MDR_OUT, 16'h0000);
    chk16("rst_rdata", rdata, 16'h0000);
    chk1("rst_done", done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    e0 = en_cnt;
    start(1'b0, 16'h0000, 16'h0000);
    chk1("rd0_busy", busy, 1'b1);
    wait_done(ok);
    chk1("rd0_done", ok, 1'b1);
    chk16("rd0_rdata", rdata, 16'hA03A);
    chk1("rd0_err", err, 1'b0);
    chk16("rd0_mar", MAR_OUT, 16'h0000);
    chk1("rd0_rw", cap_rw, 1'b1);
    chk1("rd0_busy_done", busy, 1'b1);
    chk16("rd0_pulses", 16'(en_cnt - e0), 16'd1);
    tick();
    chk1("rd0_done_low", done, 1'b0);
    chk1("rd0_idle", busy, 1'b0);

    start(1'b1, 16'hFFFF, 16'h1234);
    wait_done(ok);
    chk1("wr_done", ok, 1'b1);
    chk1("wr_rw", cap_rw, 1'b0);
    chk16("wr_mdr", cap_mdr, 16'h1234);
    chk16("wr_mar", cap_mar, 16'hFFFF);
    chk16("wr_rdata_kept", rdata, 16'hA03A);
    chk1("wr_err", err, 1'b0);
    tick();

    start(1'b0, 16'hFFFF, 16'h0000);
    wait_done(ok);
    chk1("rdf_done", ok, 1'b1);
    chk16("rdf_rdata", rdata, 16'h1234);
    tick();

    e0 = en_cnt;
    d0 = done_cnt;
    start(1'b0, 16'h0007, 16'h0000);
    tick();
    tick();
    @(negedge clk);
    req = 1'b1;
    addr = 16'h0003;
    @(negedge clk);
    req = 1'b0;
    wait_done(ok);
    chk1("rd7_done", ok, 1'b1);
    chk16("rd7_rdata", rdata, 16'h0777);
    repeat (5) tick();
    chk16("ign_pulses", 16'(en_cnt - e0), 16'd1);
    chk16("ign_dones", 16'(done_cnt - d0), 16'd1);
    chk1("ign_idle", busy, 1'b0);

    start(1'b0, 16'h0003, 16'h0000);
    wait_done(ok);
    chk1("rd3_done", ok, 1'b1);
    chk16("rd3_rdata", rdata, 16'h6002);
    tick();

    mute = 1'b1;
    start(1'b1, 16'h0003, 16'hBEEF);
    wait_en(ok);
    chk1("mid_strobe", ok, 1'b1);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk1("mid_mem_en", MEM_EN, 1'b0);
    chk1("mid_busy", busy, 1'b0);
    chk1("mid_done", done, 1'b0);
    chk1("mid_rw", RW, 1'b1);
    chk16("mid_mar", MAR_OUT, 16'h0000);
    chk16("mid_mdr", MDR_OUT, 16'h0000);
    chk16("mid_rdata", rdata, 16'h0000);
    chk1("mid_err", err, 1'b0);
    d0 = done_cnt;
    repeat (4) tick();
    @(negedge clk);
    reset = 1'b1;
    repeat (6) tick();
    chk16("mid_no_done", 16'(done_cnt - d0), 16'd0);
    chk1("mid_idle", busy, 1'b0);
    mute = 1'b0;

    start(1'b0, 16'h0003, 16'h0000);
    wait_done(ok);
    chk1("pre_tmo_done", ok, 1'b1);
    chk16("pre_tmo_rdata", rdata, 16'h6002);
    tick();

    mute = 1'b1;
    d0 = done_cnt;
    start(1'b0, 16'h0000, 16'h0000);
    wait_en(ok);
    chk1("tmo_strobe", ok, 1'b1);
`ifdef MEM_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (done) break;
    end
    chk16("tmo_latency", 16'(n), 16'(TMO));
    chk1("tmo_done", done, 1'b1);
    chk1("tmo_err", err, 1'b1);
    chk1("tmo_mem_en", MEM_EN, 1'b0);
    chk16("tmo_rdata", rdata, 16'h6002);
    tick();
    chk1("tmo_idle", busy, 1'b0);
`else
    repeat (40) tick();
    chk1("hang_busy", busy, 1'b1);
    chk1("hang_mem_en", MEM_EN, 1'b1);
    chk16("hang_no_done", 16'(done_cnt - d0), 16'd0);
    chk16("hang_rdata", rdata, 16'h6002);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
`endif
    mute = 1'b0;

    start(1'b0, 16'h0000, 16'h0000);
    wait_done(ok);
    chk1("rec_done", ok, 1'b1);
    chk16("rec_rdata", rdata, 16'hA03A);
    chk1("rec_err", err, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
